// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch PC sequencer: branch opcodes, FSM states, reset vector.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_J    = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_gen.sv
// Branch/jump target datapath: sign-extend, word-shift and add, or jump-field splice.
// Purely combinational, zero latency, no flow control.
module branch_target_gen
  import pc_seq_pkg::*;
(
  input  logic [15:0] imm_i,
  input  logic [25:0] jaddr_i,
  input  logic [31:0] br_pc_i,
  input  logic        is_jump,
  output logic [31:0] target_o
);

  logic [31:0] br_off;

  assign br_off   = {{14{imm_i[15]}}, imm_i, 2'b00};
  assign target_o = is_jump ? {br_pc_i[31:28], jaddr_i, 2'b00} : (br_pc_i + br_off);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks sequential/branch/jump/hold/halt each cycle, times the wrong-path flush.
// PC and flush update on the edge after the decision; stall_i holds the PC and defers any taken branch.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             br_valid_i,
  input  logic [1:0]       br_op_i,
  input  logic             rs_eq_i,
  input  logic [15:0]      imm_i,
  input  logic [25:0]      jaddr_i,
  input  logic [31:0]      br_pc_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      target_o,
  output logic             redirect_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_e     state;
  br_op_e     op;
  logic [1:0] flush_cnt;
  logic       taken;

  assign op = br_op_e'(br_op_i);

  branch_target_gen u_tgt (
    .imm_i    (imm_i),
    .jaddr_i  (jaddr_i),
    .br_pc_i  (br_pc_i),
    .is_jump  (op == BR_J),
    .target_o (target_o)
  );

  assign taken = br_valid_i & (((op == BR_BEQ) & rs_eq_i) |
                               ((op == BR_BNE) & ~rs_eq_i) |
                               (op == BR_J));

  // Outside RUN the resolving instruction is wrong-path or frozen, so it never redirects.
  assign redirect_o = taken & (state == ST_RUN) & ~stall_i & ~halt_i;
  assign pc_plus4_o = pc_o + 32'd4;
  assign halted_o   = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc_o        <= RESET_PC;
      flush_o     <= 1'b0;
      flush_cnt   <= 2'd0;
      taken_cnt_o <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_i) begin
            state <= ST_HALT;
          end else if (redirect_o) begin
            pc_o      <= target_o;
            state     <= ST_FLUSH;
            flush_o   <= 1'b1;
            flush_cnt <= FLUSH_INIT;
            if (taken_cnt_o != '1) taken_cnt_o <= taken_cnt_o + CNT_W'(1);
          end else if (!stall_i) begin
            pc_o <= pc_plus4_o;
          end
        end
        ST_FLUSH: begin
          // Halting abandons the remaining flush; the hazard unit drains the wrong path.
          if (halt_i) begin
            state     <= ST_HALT;
            flush_o   <= 1'b0;
            flush_cnt <= 2'd0;
          end else begin
            if (!stall_i) pc_o <= pc_plus4_o;
            if (flush_cnt == 2'd0) begin
              state   <= ST_RUN;
              flush_o <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - 2'd1;
            end
          end
        end
        ST_HALT: begin
          if (resume_i) state <= ST_RUN;
        end
        default: begin
          state   <= ST_RUN;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: default, FLUSH_CYCLES=2/CNT_W=2 and wrap-around reset-vector instances.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, resume, bv, eq;
  logic [1:0]  op;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [31:0] brpc;

  logic [31:0] pc0, pc1, pc2, p4_0, p4_1, p4_2, tg0, tg1, tg2;
  logic        rd0, rd1, rd2, fl0, fl1, fl2, hl0, hl1, hl2;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [15:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .br_valid_i(bv), .br_op_i(op), .rs_eq_i(eq), .imm_i(imm), .jaddr_i(jaddr), .br_pc_i(brpc),
    .pc_o(pc0), .pc_plus4_o(p4_0), .target_o(tg0), .redirect_o(rd0), .flush_o(fl0),
    .halted_o(hl0), .taken_cnt_o(cnt0)
  );

  pc_sequencer #(.FLUSH_CYCLES(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .br_valid_i(bv), .br_op_i(op), .rs_eq_i(eq), .imm_i(imm), .jaddr_i(jaddr), .br_pc_i(brpc),
    .pc_o(pc1), .pc_plus4_o(p4_1), .target_o(tg1), .redirect_o(rd1), .flush_o(fl1),
    .halted_o(hl1), .taken_cnt_o(cnt1)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .br_valid_i(bv), .br_op_i(op), .rs_eq_i(eq), .imm_i(imm), .jaddr_i(jaddr), .br_pc_i(brpc),
    .pc_o(pc2), .pc_plus4_o(p4_2), .target_o(tg2), .redirect_o(rd2), .flush_o(fl2),
    .halted_o(hl2), .taken_cnt_o(cnt2)
  );

  typedef struct {
    logic        stall, halt, resume, bv, eq;
    logic [1:0]  op;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] brpc;
    logic        e_rd;
    logic [31:0] e_tg;
    logic [31:0] e_pc;
    logic        e_fl, e_hl;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        fl, hl;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[23];
  exp_t sb_q[$];

  function automatic vec_t mk(logic s, logic h, logic r, logic v, logic [1:0] o, logic e,
                              logic [15:0] im, logic [25:0] ja, logic [31:0] bp,
                              logic erd, logic [31:0] etg, logic [31:0] epc,
                              logic efl, logic ehl, logic [15:0] ecnt);
    vec_t t;
    t.stall = s; t.halt = h; t.resume = r; t.bv = v; t.op = o; t.eq = e;
    t.imm = im; t.jaddr = ja; t.brpc = bp;
    t.e_rd = erd; t.e_tg = etg; t.e_pc = epc; t.e_fl = efl; t.e_hl = ehl; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic r, input logic v,
                       input logic [1:0] o, input logic e, input logic [15:0] im,
                       input logic [25:0] ja, input logic [31:0] bp);
    stall = s; halt = h; resume = r; bv = v; op = o; eq = e; imm = im; jaddr = ja; brpc = bp;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //                  st h r bv op    eq imm       jaddr     br_pc          rd tgt            pc             fl hl cnt
    vecs[0]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h4,         0,0,16'd0);
    vecs[1]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h8,         0,0,16'd0);
    vecs[2]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'hC,         0,0,16'd0);
    vecs[3]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h10,        0,0,16'd0);
    vecs[4]  = mk(0,0,0,1,2'b01,1,16'h000F,26'h0,    32'hC,         1,32'h48,       32'h48,        1,0,16'd1);
    vecs[5]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h4C,        0,0,16'd1);
    vecs[6]  = mk(0,0,0,1,2'b10,0,16'hFFFE,26'h0,    32'h100,       1,32'hF8,       32'hF8,        1,0,16'd2);
    vecs[7]  = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'hFC,        0,0,16'd2);
    vecs[8]  = mk(0,0,0,1,2'b10,1,16'hFFFE,26'h0,    32'h100,       0,32'hF8,       32'h100,       0,0,16'd2);
    vecs[9]  = mk(0,0,0,1,2'b11,0,16'h0000,26'h40,   32'h1000_0004, 1,32'h1000_0100,32'h1000_0100, 1,0,16'd3);
    vecs[10] = mk(0,0,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       0,32'h240,      32'h1000_0104, 0,0,16'd3);
    vecs[11] = mk(1,0,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       0,32'h240,      32'h1000_0104, 0,0,16'd3);
    vecs[12] = mk(0,0,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       1,32'h240,      32'h240,       1,0,16'd4);
    vecs[13] = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h244,       0,0,16'd4);
    vecs[14] = mk(0,0,0,1,2'b00,1,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h248,       0,0,16'd4);
    vecs[15] = mk(0,1,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       0,32'h240,      32'h248,       0,1,16'd4);
    vecs[16] = mk(0,0,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       0,32'h240,      32'h248,       0,1,16'd4);
    vecs[17] = mk(0,1,1,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h248,       0,0,16'd4);
    vecs[18] = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h24C,       0,0,16'd4);
    vecs[19] = mk(0,0,0,1,2'b01,1,16'h0010,26'h0,    32'h200,       1,32'h240,      32'h240,       1,0,16'd5);
    vecs[20] = mk(0,1,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h240,       0,1,16'd5);
    vecs[21] = mk(0,0,1,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h240,       0,0,16'd5);
    vecs[22] = mk(0,0,0,0,2'b00,0,16'h0000,26'h0,    32'h0,         0,32'h0,        32'h244,       0,0,16'd5);

    // Reset state of every instance
    do_reset();
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_flush0", 32'(fl0), 32'h0);
    chk("rst_halted0", 32'(hl0), 32'h0);
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    chk("rst_pc2", pc2, 32'hFFFF_FFF8);
    chk("rst_pc_plus4_0", p4_0, 32'h4);

    // Table-driven run on the default instance
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].stall, vecs[i].halt, vecs[i].resume, vecs[i].bv, vecs[i].op, vecs[i].eq,
            vecs[i].imm, vecs[i].jaddr, vecs[i].brpc);
      @(negedge clk);
      chk($sformatf("v%0d_redirect", i), 32'(rd0), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_target", i), tg0, vecs[i].e_tg);
      e.idx = i; e.pc = vecs[i].e_pc; e.fl = vecs[i].e_fl; e.hl = vecs[i].e_hl; e.cnt = vecs[i].e_cnt;
      sb_q.push_back(e);
      tick();
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_pc", e.idx), pc0, e.pc);
        chk($sformatf("v%0d_flush", e.idx), 32'(fl0), 32'(e.fl));
        chk($sformatf("v%0d_halted", e.idx), 32'(hl0), 32'(e.hl));
        chk($sformatf("v%0d_cnt", e.idx), 32'(cnt0), 32'(e.cnt));
      end
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    // PC wrap and halt/resume on the high reset-vector instance
    do_reset();
    tick();
    chk("wrap_pc_fffffffc", pc2, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_0", pc2, 32'h0);
    drive(0, 1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    tick();
    chk("halt_pc", pc2, 32'h0);
    chk("halt_halted", 32'(hl2), 32'h1);
    tick();
    chk("halt_pc_frozen", pc2, 32'h0);
    drive(0, 1, 1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    tick();
    chk("resume_halted", 32'(hl2), 32'h0);
    chk("resume_pc", pc2, 32'h0);
    idle();
    tick();
    chk("resume_pc_inc", pc2, 32'h4);

    // Two-cycle flush with a wrong-path branch inside it, then counter saturation
    do_reset();
    drive(0, 0, 0, 1, 2'b11, 0, 16'h0, 26'h40, 32'h1000_0004);
    @(negedge clk);
    chk("j_redirect1", 32'(rd1), 32'h1);
    tick();
    chk("j_pc1", pc1, 32'h1000_0100);
    chk("j_flush1_c1", 32'(fl1), 32'h1);
    drive(0, 0, 0, 1, 2'b01, 1, 16'h000F, 26'h0, 32'hC);
    @(negedge clk);
    chk("flush_br_ignored_redirect", 32'(rd1), 32'h0);
    tick();
    chk("j_flush1_c2", 32'(fl1), 32'h1);
    chk("flush_br_ignored_pc", pc1, 32'h1000_0104);
    idle();
    tick();
    chk("j_flush1_done", 32'(fl1), 32'h0);
    chk("j_pc1_after", pc1, 32'h1000_0108);
    chk("sat_cnt_1", 32'(cnt1), 32'h1);
    for (int k = 2; k <= 5; k++) begin
      drive(0, 0, 0, 1, 2'b11, 0, 16'h0, 26'h40, 32'h1000_0004);
      tick();
      idle();
      tick();
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt1), (k > 3) ? 32'h3 : 32'(k));
    end

    // Asynchronous reset while a flush is in progress
    do_reset();
    drive(0, 0, 0, 1, 2'b01, 1, 16'h000F, 26'h0, 32'hC);
    tick();
    chk("pre_rst_flush0", 32'(fl0), 32'h1);
    chk("pre_rst_pc0", pc0, 32'h48);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flush0", 32'(fl0), 32'h0);
    chk("async_rst_pc0", pc0, 32'h0);
    chk("async_rst_cnt0", 32'(cnt0), 32'h0);
    chk("async_rst_flush1", 32'(fl1), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_pc0", pc0, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the fetch PC register and sequences the branch-target datapath (sign-extend, shift-by-2, add to PC+4) for the single-issue MIPS-style core. Each cycle it chooses the next PC from sequential, branch, jump, hold or halt. On a taken redirect it drives a timed pipeline flush. It also keeps a saturating taken-branch counter for bring-up.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
FLUSH_CYCLES, 1, cycles flush_o stays high after a redirect (range 1-3)
CNT_W, 16, width of the taken-branch counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
stall_i  in  1  hold PC (hazard unit)
halt_i  in  1  request halt
resume_i  in  1  leave HALT
br_valid_i  in  1  control-flow instruction resolved this cycle
br_op_i  in  2  00 none, 01 BEQ, 10 BNE, 11 J
rs_eq_i  in  1  register-compare result (rs==rt)
imm_i  in  16  branch offset in words, signed
jaddr_i  in  26  jump field
br_pc_i  in  32  PC+4 of the resolving instruction
pc_o  out  32  current fetch PC (registered)
pc_plus4_o  out  32  pc_o+4, combinational
target_o  out  32  computed target, combinational
redirect_o  out  1  taken decision this cycle, combinational
flush_o  out  1  kill the wrong-path IF/ID contents (registered)
halted_o  out  1  state==HALT
taken_cnt_o  out  CNT_W  taken redirects since reset

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC, state=RUN, flush_o=0, halted_o=0, taken_cnt_o=0, internal flush counter=0.
  - Reset asserted mid-FLUSH or mid-HALT aborts it immediately.
- Target arithmetic:
  - Branch target = br_pc_i + {{14{imm_i[15]}}, imm_i, 2'b00}, modulo 2^32.
  - Jump target = {br_pc_i[31:28], jaddr_i, 2'b00}.
  - target_o[1:0] is always 00.
- taken = br_valid_i & ((op==BEQ & rs_eq_i) | (op==BNE & !rs_eq_i) | op==J).
- redirect_o = taken & state==RUN & !stall_i & !halt_i.
- op==00 with br_valid_i=1 is not taken.
- Sequential increment: pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- States RUN, FLUSH, HALT. Next-edge priority within each state is highest first.
- RUN:
  - halt_i -> HALT, pc holds.
  - redirect_o -> pc<=target_o, state FLUSH, flush counter<=FLUSH_CYCLES-1, taken_cnt++.
  - stall_i -> pc holds.
  - otherwise pc<=pc+4.
- FLUSH:
  - flush_o=1 for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge.
  - br_valid_i is ignored (it belongs to the wrong path).
  - pc<=pc+4 unless stall_i.
  - halt_i -> HALT, with flush_o cleared at that edge. The pending flush is abandoned; the hazard unit drains the wrong path.
  - At counter==0 -> RUN.
- HALT:
  - pc holds, flush_o=0, halted_o=1, branches ignored.
  - resume_i -> RUN. halt_i is ignored while in HALT; resume_i wins if both are high.
- Stall and taken together in RUN: the branch is not taken this cycle. The hazard unit re-presents it once the stall clears.
- taken_cnt_o saturates at all-ones; no wrap.
- All outputs except pc_plus4_o, target_o and redirect_o are registered.

Decomposition:
- Package pc_seq_pkg holds:
  - br_op codes (BR_NONE, BR_BEQ, BR_BNE, BR_J)
  - state encoding (ST_RUN, ST_FLUSH, ST_HALT)
  - the default reset vector constant
- Sub-module branch_target_gen: purely combinational. Inputs imm_i, jaddr_i, br_pc_i, is_jump. Output is the 32-bit target (sign-extend, shift, add, or jump concatenation). Instantiated once.

Test Plan:
- Branch target: after reset, pc=0. Four free cycles -> pc=0x10. Then BEQ, imm=0x000F, br_pc=0x0000_000C, eq=1 -> redirect_o=1, target_o=0x0000_0048. Next edge pc=0x48, flush_o=1 for 1 cycle, taken_cnt=1.
- Negative offset: BNE, imm=0xFFFE, br_pc=0x0000_0100, eq=0 -> pc=0x0000_00F8. Same op with eq=1 -> not taken, pc+4, flush_o stays 0.
- Jump: jaddr=0x0000040, br_pc=0x1000_0004 -> pc=0x1000_0100. With FLUSH_CYCLES=2, flush_o high 2 cycles. A second br_valid_i during FLUSH is ignored.
- Stall plus branch: stall_i=1 with BEQ taken -> pc holds, redirect_o=0, counter unchanged. Release stall with BEQ re-presented -> redirect occurs.
- Wrap and halt: RESET_PC=0xFFFF_FFF8, free run -> 0xFFFF_FFFC, then 0x0000_0000. halt_i -> pc frozen, halted_o=1. halt_i and resume_i together in HALT -> RUN next edge.
- Reset mid-FLUSH: rst_n low asynchronously while flush_o=1 -> flush_o=0 and pc=RESET_PC without waiting for a clock edge. Counter saturation is forced via CNT_W=2: 5 taken branches -> taken_cnt_o=3.
